// File: rtl/rx_frame_packer_pkg.sv
// Shared 8b10b K-code constants, framing states and symbol classification for the rx word packer.
package rx_frame_packer_pkg;

  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_7 = 8'hFC;

  localparam logic [8:0] IDLE_SLOT = {1'b1, K28_1};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } frame_state_e;

  typedef enum logic [2:0] {
    SYM_DATA,
    SYM_SOF,
    SYM_EOF,
    SYM_IDLE,
    SYM_ILLEGAL
  } sym_class_e;

  function automatic sym_class_e classify(input logic k, input logic [7:0] d);
    sym_class_e c;
    if (!k) begin
      c = SYM_DATA;
    end else begin
      case (d)
        K28_7, K28_5: c = SYM_SOF;
        K28_2, K28_3: c = SYM_EOF;
        K28_1:        c = SYM_IDLE;
        default:      c = SYM_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output; a push into a full FIFO
// is only taken when a pop frees a slot in the same cycle, and rd_data reads zero while empty.
module rx_sync_fifo #(
  parameter int DSIZE = 27,
  parameter int ASIZE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_vld,
  output logic             full,
  output logic [ASIZE:0]   size
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ASIZE:0]   size_q, size_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    rd_vld   = (size_q != '0);
    full     = (size_q == (ASIZE+1)'(DEPTH));
    rd_ok    = rd_en & rd_vld;
    wr_ok    = wr_en & (~full | rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + ASIZE'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + ASIZE'(1) : rd_ptr_q;
    case ({wr_ok, rd_ok})
      2'b10:   size_d = size_q + (ASIZE+1)'(1);
      2'b01:   size_d = size_q - (ASIZE+1)'(1);
      default: size_d = size_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      size_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      size_q   <= size_d;
    end
  end

  assign rd_data = rd_vld ? mem[rd_ptr_q] : '0;
  assign size    = size_q;

endmodule

// File: rtl/rx_frame_packer.sv
// Packs decoded 8b10b symbols into BYTES_PER_WORD-slot words, pads partial words with K28.1,
// tracks SOF/EOF framing and keeps saturating lost/decoder/framing error counters.
module rx_frame_packer
  import rx_frame_packer_pkg::*;
#(
  parameter int BYTES_PER_WORD = 3,
  parameter int ASIZE          = 3,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                        WCLK,
  input  logic                        RESET_N,
  input  logic                        enable_rx,
  input  logic                        cnt_clear,
  input  logic                        sym_valid,
  input  logic                        sym_k,
  input  logic [7:0]                  sym_data,
  input  logic                        sym_err,
  output logic [9*BYTES_PER_WORD-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ASIZE:0]              fifo_size,
  output logic                        in_frame,
  output logic [CNT_WIDTH-1:0]        lost_err_cnt,
  output logic [CNT_WIDTH-1:0]        decoder_err_cnt,
  output logic [CNT_WIDTH-1:0]        frame_err_cnt
);

  localparam int BPW = BYTES_PER_WORD;
  localparam int DW  = 9 * BPW;
  localparam int SW  = $clog2(BPW);

  sym_class_e     cls;
  frame_state_e   state_q, state_d;
  logic [SW-1:0]  byte_sel_q, byte_sel_d;
  logic [8:0]     slot_q [BPW];
  logic [8:0]     slot_d [BPW];
  logic [8:0]     sym_slot;
  logic [DW-1:0]  word;
  logic           acc, pack, flush, push, fifo_full;
  logic           lost_ev, dec_ev, frame_ev;
  logic [CNT_WIDTH-1:0] lost_d, dec_d, frame_d;
  logic [CNT_WIDTH-1:0] lost_q, dec_q, frame_q;

  function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] c,
                                                    input logic ev, input logic clr);
    if (clr)                return '0;
    if (ev && (c != '1))    return c + CNT_WIDTH'(1);
    return c;
  endfunction

  always_comb begin
    cls      = classify(sym_k, sym_data);
    sym_slot = {sym_k, sym_data};
    acc      = sym_valid & enable_rx;
    pack     = acc & ((cls == SYM_DATA) | (cls == SYM_SOF) | (cls == SYM_EOF));
    // Disabling the lane flushes a partial word exactly like an IDLE symbol would.
    flush    = (byte_sel_q != '0) & ((acc & (cls == SYM_IDLE)) | ~enable_rx);
    push     = (pack & (byte_sel_q == SW'(BPW-1))) | flush;

    word = '0;
    for (int i = 0; i < BPW; i++) begin
      if (SW'(i) < byte_sel_q)                  word[DW-1-9*i -: 9] = slot_q[i];
      else if (pack && (SW'(i) == byte_sel_q))  word[DW-1-9*i -: 9] = sym_slot;
      else                                      word[DW-1-9*i -: 9] = IDLE_SLOT;
    end

    for (int i = 0; i < BPW; i++) slot_d[i] = slot_q[i];
    if (pack) slot_d[byte_sel_q] = sym_slot;

    if (push)      byte_sel_d = '0;
    else if (pack) byte_sel_d = byte_sel_q + SW'(1);
    else           byte_sel_d = byte_sel_q;

    state_d  = state_q;
    frame_ev = 1'b0;
    if (acc) begin
      case (cls)
        SYM_SOF:     if (state_q == S_IDLE) state_d = S_FRAME; else frame_ev = 1'b1;
        SYM_EOF:     if (state_q == S_FRAME) state_d = S_IDLE; else frame_ev = 1'b1;
        SYM_DATA:    if (state_q == S_IDLE) frame_ev = 1'b1;
        SYM_ILLEGAL: frame_ev = 1'b1;
        default:     ;
      endcase
    end

    lost_ev = push & fifo_full & ~(out_valid & out_ready);
    dec_ev  = acc & sym_err;
    lost_d  = sat_next(lost_q, lost_ev, cnt_clear);
    dec_d   = sat_next(dec_q, dec_ev, cnt_clear);
    frame_d = sat_next(frame_q, frame_ev, cnt_clear);
  end

  always_ff @(posedge WCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      byte_sel_q <= '0;
      for (int i = 0; i < BPW; i++) slot_q[i] <= '0;
      lost_q     <= '0;
      dec_q      <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      for (int i = 0; i < BPW; i++) slot_q[i] <= slot_d[i];
      lost_q     <= lost_d;
      dec_q      <= dec_d;
      frame_q    <= frame_d;
    end
  end

  rx_sync_fifo #(
    .DSIZE (DW),
    .ASIZE (ASIZE)
  ) u_fifo (
    .clk     (WCLK),
    .rst_n   (RESET_N),
    .wr_en   (push),
    .wr_data (word),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .rd_vld  (out_valid),
    .full    (fifo_full),
    .size    (fifo_size)
  );

  assign in_frame        = (state_q == S_FRAME);
  assign lost_err_cnt    = lost_q;
  assign decoder_err_cnt = dec_q;
  assign frame_err_cnt   = frame_q;

endmodule

// File: tb/tb_rx_frame_packer.sv
// Directed scoreboard bench for rx_frame_packer with BPW=3, ASIZE=2, CNT_WIDTH=4.
module tb_rx_frame_packer;

  logic        WCLK, RESET_N, enable_rx, cnt_clear;
  logic        sym_valid, sym_k, sym_err, out_valid, out_ready, in_frame;
  logic [7:0]  sym_data;
  logic [26:0] out_data;
  logic [2:0]  fifo_size;
  logic [3:0]  lost_err_cnt, decoder_err_cnt, frame_err_cnt;

  logic [26:0] exp_q [$];
  int vecs = 0;
  int errs = 0;

  rx_frame_packer #(.BYTES_PER_WORD(3), .ASIZE(2), .CNT_WIDTH(4)) dut (
    .WCLK(WCLK), .RESET_N(RESET_N), .enable_rx(enable_rx), .cnt_clear(cnt_clear),
    .sym_valid(sym_valid), .sym_k(sym_k), .sym_data(sym_data), .sym_err(sym_err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_size(fifo_size), .in_frame(in_frame), .lost_err_cnt(lost_err_cnt),
    .decoder_err_cnt(decoder_err_cnt), .frame_err_cnt(frame_err_cnt)
  );

  initial begin
    WCLK = 1'b0;
    forever #5 WCLK = ~WCLK;
  end

  function automatic logic [26:0] w3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
    return {a, b, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one symbol for exactly one rising edge.
  task automatic put(input logic k, input logic [7:0] d, input logic e);
    sym_valid = 1'b1; sym_k = k; sym_data = d; sym_err = e;
    @(negedge WCLK);
    sym_valid = 1'b0; sym_k = 1'b0; sym_data = 8'h00; sym_err = 1'b0;
  endtask

  task automatic sd(input logic [7:0] d); put(1'b0, d, 1'b0); endtask
  task automatic sk(input logic [7:0] d); put(1'b1, d, 1'b0); endtask

  task automatic drain(input int n);
    logic [26:0] e;
    out_ready = 1'b1;
    for (int j = 0; j < n; j++) begin
      int t = 0;
      while (!out_valid && t < 20) begin
        @(negedge WCLK);
        t++;
      end
      chk("drain_valid", 32'(out_valid), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h0;
      chk("drain_word", 32'(out_data), 32'(e));
      @(negedge WCLK);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; enable_rx = 1'b0; cnt_clear = 1'b0; out_ready = 1'b0;
    sym_valid = 1'b0; sym_k = 1'b0; sym_data = 8'h00; sym_err = 1'b0;
    @(negedge WCLK);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_size", 32'(fifo_size), 32'd0);
    chk("rst_in_frame", 32'(in_frame), 32'd0);
    chk("rst_cnts", {20'd0, lost_err_cnt, decoder_err_cnt, frame_err_cnt}, 32'd0);
    RESET_N = 1'b1;
    enable_rx = 1'b1;
    @(negedge WCLK);

    // Framed packet with IDLE-padded tail
    sk(8'hFC);
    chk("sof_in_frame", 32'(in_frame), 32'd1);
    sd(8'h11); sd(8'h22);
    exp_q.push_back(w3(9'h1FC, 9'h011, 9'h022));
    sd(8'h33); sk(8'h5C);
    chk("eof_in_frame", 32'(in_frame), 32'd0);
    sk(8'h3C);
    exp_q.push_back(w3(9'h033, 9'h15C, 9'h13C));
    chk("pkt_size", 32'(fifo_size), 32'd2);
    chk("pkt_frame_err", 32'(frame_err_cnt), 32'd0);
    drain(2);

    // Single byte flushed by IDLE; IDLE at slot 0 is a no-op
    sd(8'hAA); sk(8'h3C);
    exp_q.push_back(w3(9'h0AA, 9'h13C, 9'h13C));
    sk(8'h3C); sk(8'h3C);
    chk("idle_noop_size", 32'(fifo_size), 32'd1);
    chk("aa_frame_err", 32'(frame_err_cnt), 32'd1);
    drain(1);

    // Overflow: five words into a four-deep FIFO
    sk(8'hFC); sd(8'h01); sd(8'h02);
    exp_q.push_back(w3(9'h1FC, 9'h001, 9'h002));
    for (int i = 0; i < 3; i++) begin
      sd(8'(8'h10 + 3*i)); sd(8'(8'h11 + 3*i)); sd(8'(8'h12 + 3*i));
      exp_q.push_back(w3(9'(9'h010 + 3*i), 9'(9'h011 + 3*i), 9'(9'h012 + 3*i)));
    end
    sd(8'h0D); sd(8'h0E); sk(8'h7C);
    chk("ovf_size", 32'(fifo_size), 32'd4);
    chk("ovf_lost", 32'(lost_err_cnt), 32'd1);
    chk("ovf_frame_err", 32'(frame_err_cnt), 32'd1);
    drain(4);
    chk("ovf_in_frame", 32'(in_frame), 32'd0);

    // Framing violations and illegal K
    cnt_clear = 1'b1;
    @(negedge WCLK);
    cnt_clear = 1'b0;
    chk("clr_all", {20'd0, lost_err_cnt, decoder_err_cnt, frame_err_cnt}, 32'd0);
    sd(8'h55);
    chk("ferr_data_idle", 32'(frame_err_cnt), 32'd1);
    sk(8'hFC); sk(8'hBC);
    exp_q.push_back(w3(9'h055, 9'h1FC, 9'h1BC));
    chk("ferr_double_sof", 32'(frame_err_cnt), 32'd2);
    sk(8'hF7);
    chk("ferr_illegal_k", 32'(frame_err_cnt), 32'd3);
    chk("illegal_size", 32'(fifo_size), 32'd1);
    sd(8'h66); sk(8'h5C); sk(8'h3C);
    exp_q.push_back(w3(9'h066, 9'h15C, 9'h13C));
    drain(2);

    // Decoder error saturation and clear priority
    for (int i = 0; i < 15; i++) put(1'b1, 8'h3C, 1'b1);
    chk("dec_15", 32'(decoder_err_cnt), 32'd15);
    for (int i = 0; i < 5; i++) put(1'b1, 8'h3C, 1'b1);
    chk("dec_sat", 32'(decoder_err_cnt), 32'd15);
    chk("dec_no_push", 32'(fifo_size), 32'd0);
    cnt_clear = 1'b1;
    put(1'b1, 8'hF7, 1'b1);
    cnt_clear = 1'b0;
    chk("clr_wins", {20'd0, lost_err_cnt, decoder_err_cnt, frame_err_cnt}, 32'd0);

    // Disabling the lane flushes the partial word; disabled symbols are ignored
    sd(8'h77);
    enable_rx = 1'b0;
    sd(8'h99);
    exp_q.push_back(w3(9'h077, 9'h13C, 9'h13C));
    sd(8'h99);
    chk("dis_size", 32'(fifo_size), 32'd1);
    chk("dis_frame_err", 32'(frame_err_cnt), 32'd1);
    enable_rx = 1'b1;
    drain(1);

    // Asynchronous reset with a stored word and a partial word
    sk(8'hFC); sd(8'h0B); sd(8'h0C);
    sd(8'h01); sd(8'h02);
    chk("pre_rst_size", 32'(fifo_size), 32'd1);
    chk("pre_rst_in_frame", 32'(in_frame), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_size", 32'(fifo_size), 32'd0);
    chk("arst_in_frame", 32'(in_frame), 32'd0);
    chk("arst_frame_err", 32'(frame_err_cnt), 32'd0);
    exp_q.delete();
    @(negedge WCLK);
    RESET_N = 1'b1;
    sd(8'h01); sd(8'h02); sd(8'h03);
    exp_q.push_back(w3(9'h001, 9'h002, 9'h003));
    chk("post_rst_size", 32'(fifo_size), 32'd1);
    drain(1);
    chk("post_rst_frame_err", 32'(frame_err_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
